wt_dcache_mem_responder: RTL and testbench



---
 rtl/wt_dcache_mem_responder.sv | 216 +++++++++++++++++++++
 tb/tb_wt_dcache_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_mem_responder.sv
// Synthesizable memory-side responder for the write-through D$ req/rtrn interface.
// Services loads, stores and atomics from a local word array with in-order, credit-limited returns.
module wt_dcache_mem_responder #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned LineWidth = 128,
  parameter int unsigned PlenWidth = 56,
  parameter int unsigned TidWidth  = 2,
  parameter int unsigned MemWords  = 1024,
  parameter int unsigned Latency   = 2,
  parameter int unsigned RtrnDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_data_req_i,
  output logic                 mem_data_ack_o,
  input  logic [1:0]           req_rtype_i,
  input  logic [2:0]           req_size_i,
  input  logic [PlenWidth-1:0] req_paddr_i,
  input  logic [XLEN-1:0]      req_data_i,
  input  logic                 req_nc_i,
  input  logic [TidWidth-1:0]  req_tid_i,
  input  logic                 req_amo_op_i,
  input  logic                 rtrn_hold_i,
  output logic                 mem_rtrn_vld_o,
  output logic [1:0]           rtrn_rtype_o,
  output logic [LineWidth-1:0] rtrn_data_o,
  output logic [TidWidth-1:0]  rtrn_tid_o,
  output logic                 err_o
);

  localparam int unsigned WordsPerLine = LineWidth / XLEN;
  localparam int unsigned IdxW         = $clog2(MemWords);
  localparam int unsigned PipeDepth    = (Latency > 1) ? Latency - 1 : 1;
  localparam int unsigned PtrW         = (RtrnDepth > 1) ? $clog2(RtrnDepth) : 1;
  localparam int unsigned CntW         = $clog2(RtrnDepth + 1);
  localparam logic [IdxW-1:0] LineMask = IdxW'(WordsPerLine - 1);
  localparam logic [1:0] RtLoad   = 2'd0;
  localparam logic [1:0] RtStore  = 2'd1;
  localparam logic [1:0] RtAtomic = 2'd2;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RtrnDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  logic [XLEN-1:0]      mem_r [MemWords];
  logic                 pipe_vld_r [PipeDepth];
  logic [1:0]           pipe_rt_r [PipeDepth];
  logic [LineWidth-1:0] pipe_data_r [PipeDepth];
  logic [TidWidth-1:0]  pipe_tid_r [PipeDepth];
  logic [1:0]           fifo_rt_r [RtrnDepth];
  logic [LineWidth-1:0] fifo_data_r [RtrnDepth];
  logic [TidWidth-1:0]  fifo_tid_r [RtrnDepth];
  logic [PtrW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CntW-1:0]      fifo_cnt_r;
  logic                 vld_r, err_r;
  logic [1:0]           out_rt_r;
  logic [LineWidth-1:0] out_data_r;
  logic [TidWidth-1:0]  out_tid_r;

  logic                 ack_s, pop_s, st_ok_s, amo_ok_s, we_s, err_set_s;
  logic [31:0]          inflight_s;
  logic [IdxW-1:0]      idx_s, line_base_s;
  logic [2:0]           off_s;
  logic [7:0]           be_s;
  logic [XLEN-1:0]      old_s, wmask_s, wdata_s;
  logic [LineWidth-1:0] line_s;
  logic                 res_vld_s, push_vld_s;
  logic [1:0]           res_rt_s, push_rt_s;
  logic [LineWidth-1:0] res_data_s, push_data_s;
  logic [TidWidth-1:0]  push_tid_s;
  logic                 unused_s;

  assign idx_s       = req_paddr_i[IdxW+2:3];
  assign off_s       = req_paddr_i[2:0];
  assign line_base_s = idx_s & ~LineMask;
  assign old_s       = mem_r[idx_s];
  assign unused_s    = ^{req_paddr_i[PlenWidth-1:IdxW+3], req_nc_i};

  // Credits cover both the return FIFO and results still travelling down the pipeline.
  always_comb begin
    inflight_s = 32'(fifo_cnt_r);
    for (int k = 0; k < PipeDepth; k++) begin
      inflight_s = inflight_s + 32'(pipe_vld_r[k]);
    end
  end

  assign ack_s          = mem_data_req_i && (inflight_s < 32'(RtrnDepth)) && !rst_i;
  assign mem_data_ack_o = ack_s;

  // Decode the accepted request: byte enables, legality, array write and result payload.
  always_comb begin
    be_s    = 8'h00;
    st_ok_s = 1'b0;
    case (req_size_i)
      3'b000: begin be_s = 8'h01 << off_s; st_ok_s = 1'b1;               end
      3'b001: begin be_s = 8'h03 << off_s; st_ok_s = (off_s[0] == 1'b0);   end
      3'b010: begin be_s = 8'h0F << off_s; st_ok_s = (off_s[1:0] == 2'b00); end
      3'b011: begin be_s = 8'hFF;          st_ok_s = (off_s == 3'b000);    end
      default: begin be_s = 8'h00;         st_ok_s = 1'b0;                 end
    endcase
    amo_ok_s = (req_size_i == 3'b011) && (off_s == 3'b000);
    wmask_s  = '0;
    for (int b = 0; b < 8; b++) begin
      wmask_s[b*8 +: 8] = {8{be_s[b]}};
    end
    line_s = '0;
    for (int i = 0; i < WordsPerLine; i++) begin
      line_s[i*XLEN +: XLEN] = mem_r[line_base_s + IdxW'(i)];
    end
    we_s       = 1'b0;
    wdata_s    = old_s;
    res_vld_s  = 1'b0;
    res_rt_s   = RtLoad;
    res_data_s = '0;
    err_set_s  = 1'b0;
    case (req_rtype_i)
      RtLoad: begin
        res_vld_s  = ack_s;
        res_data_s = line_s;
      end
      RtStore: begin
        res_vld_s = ack_s;
        res_rt_s  = RtStore;
        we_s      = ack_s && st_ok_s;
        wdata_s   = (old_s & ~wmask_s) | (req_data_i & wmask_s);
        err_set_s = ack_s && !st_ok_s;
      end
      RtAtomic: begin
        res_vld_s  = ack_s;
        res_rt_s   = RtAtomic;
        res_data_s = LineWidth'(old_s);
        we_s       = ack_s && amo_ok_s;
        wdata_s    = req_amo_op_i ? (old_s + req_data_i) : req_data_i;
        err_set_s  = ack_s && !amo_ok_s;
      end
      default: begin
        err_set_s = ack_s;
      end
    endcase
  end

  // Word array write on the ack cycle; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_s) mem_r[idx_s] <= wdata_s;
  end

  // Latency pipeline: with Latency==1 the result goes straight into the FIFO.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < PipeDepth; k++) begin
      if (rst_i) begin
        pipe_vld_r[k] <= 1'b0;
      end else if (k == 0) begin
        pipe_vld_r[k] <= (Latency > 1) ? res_vld_s : 1'b0;
      end else begin
        pipe_vld_r[k] <= pipe_vld_r[k-1];
      end
      pipe_rt_r[k]   <= (k == 0) ? res_rt_s   : pipe_rt_r[(k == 0) ? 0 : k-1];
      pipe_data_r[k] <= (k == 0) ? res_data_s : pipe_data_r[(k == 0) ? 0 : k-1];
      pipe_tid_r[k]  <= (k == 0) ? req_tid_i  : pipe_tid_r[(k == 0) ? 0 : k-1];
    end
  end

  assign push_vld_s  = (Latency > 1) ? pipe_vld_r[PipeDepth-1]  : res_vld_s;
  assign push_rt_s   = (Latency > 1) ? pipe_rt_r[PipeDepth-1]   : res_rt_s;
  assign push_data_s = (Latency > 1) ? pipe_data_r[PipeDepth-1] : res_data_s;
  assign push_tid_s  = (Latency > 1) ? pipe_tid_r[PipeDepth-1]  : req_tid_i;
  assign pop_s       = (fifo_cnt_r != CntW'(0)) && !rtrn_hold_i;

  // Return FIFO storage.
  always_ff @(posedge clk_i) begin
    if (push_vld_s) begin
      fifo_rt_r[wr_ptr_r]   <= push_rt_s;
      fifo_data_r[wr_ptr_r] <= push_data_s;
      fifo_tid_r[wr_ptr_r]  <= push_tid_s;
    end
  end

  // FIFO pointers/count and the registered one-cycle return strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
      vld_r      <= 1'b0;
      out_rt_r   <= 2'b00;
      out_data_r <= '0;
      out_tid_r  <= '0;
    end else begin
      if (push_vld_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)      rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_vld_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CntW'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CntW'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      vld_r      <= pop_s;
      out_rt_r   <= pop_s ? fifo_rt_r[rd_ptr_r]   : 2'b00;
      out_data_r <= pop_s ? fifo_data_r[rd_ptr_r] : '0;
      out_tid_r  <= pop_s ? fifo_tid_r[rd_ptr_r]  : '0;
    end
  end

  // Sticky protocol error.
  always_ff @(posedge clk_i) begin
    if (rst_i)          err_r <= 1'b0;
    else if (err_set_s) err_r <= 1'b1;
    else                err_r <= err_r;
  end

  assign mem_rtrn_vld_o = vld_r;
  assign rtrn_rtype_o   = out_rt_r;
  assign rtrn_data_o    = out_data_r;
  assign rtrn_tid_o     = out_tid_r;
  assign err_o          = err_r;

endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
// Scoreboard bench for wt_dcache_mem_responder: a byte-level memory model predicts
// every return, which is queued at acceptance and compared when the strobe fires.
module tb_wt_dcache_mem_responder;
  localparam int L  = 2;
  localparam int D  = 4;
  localparam int MW = 1024;

  logic         clk = 1'b0;
  logic         rst, req, ack, nc, amo, hold, vld, err;
  logic [1:0]   rtype, tid, rt_o, tid_o;
  logic [2:0]   size;
  logic [55:0]  paddr;
  logic [63:0]  wdata;
  logic [127:0] data_o;

  always #5 clk = ~clk;

  wt_dcache_mem_responder #(
    .XLEN(64), .LineWidth(128), .PlenWidth(56), .TidWidth(2),
    .MemWords(MW), .Latency(L), .RtrnDepth(D)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mem_data_req_i(req), .mem_data_ack_o(ack),
    .req_rtype_i(rtype), .req_size_i(size), .req_paddr_i(paddr), .req_data_i(wdata),
    .req_nc_i(nc), .req_tid_i(tid), .req_amo_op_i(amo), .rtrn_hold_i(hold),
    .mem_rtrn_vld_o(vld), .rtrn_rtype_o(rt_o), .rtrn_data_o(data_o),
    .rtrn_tid_o(tid_o), .err_o(err)
  );

  typedef struct {
    logic [1:0]   rt;
    logic [127:0] data;
    logic [1:0]   tid;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model [MW];
  bit          exp_err = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [55:0] a);
    return int'((a >> 3) % 56'(MW));
  endfunction

  function automatic logic [127:0] model_line(input logic [55:0] a);
    int base;
    base = widx(a) & ~1;
    return {model[base + 1], model[base]};
  endfunction

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] rt, input logic [2:0] sz, input logic [55:0] a,
                      input logic [63:0] d, input logic op, input logic [1:0] t, input bit lat);
    exp_t e;
    bit got;
    int w, k, nbytes;
    bit legal;
    rtype = rt; size = sz; paddr = a; wdata = d; amo = op; tid = t; nc = 1'b0;
    req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ack === 1'b1) got = 1'b1;
    end
    if (!got) begin
      check_val("ack_timeout", 128'd0, 128'd1);
    end else begin
      w      = widx(a);
      nbytes = (sz <= 3'd3) ? (1 << sz) : 0;
      legal  = (sz <= 3'd3) && ((int'(a[2:0]) % ((nbytes == 0) ? 1 : nbytes)) == 0);
      e.tid = t; e.cyc = cyc; e.lat = lat; e.data = '0; e.rt = rt;
      case (rt)
        2'd0: begin e.data = model_line(a); sb.push_back(e); end
        2'd1: begin
          if (legal) begin
            for (int b = 0; b < nbytes; b++) begin
              k = int'(a[2:0]) + b;
              model[w][8*k +: 8] = d[8*k +: 8];
            end
          end else begin
            exp_err = 1'b1;
          end
          sb.push_back(e);
        end
        2'd2: begin
          e.data = {64'd0, model[w]};
          if (sz == 3'd3 && a[2:0] == 3'd0) model[w] = op ? model[w] + d : d;
          else exp_err = 1'b1;
          sb.push_back(e);
        end
        default: exp_err = 1'b1;
      endcase
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check_val("drain", 128'(sb.size()), 128'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Return monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b0 && vld === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_vld", 128'd1, 128'd0);
      end else begin
        e = sb.pop_front();
        check_val("rtype", 128'(rt_o), 128'(e.rt));
        check_val("tid", 128'(tid_o), 128'(e.tid));
        check_val("data", data_o, e.data);
        if (e.lat) check_val("latency", 128'(cyc - e.cyc), 128'(L + 1));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int acks, vlds;
    rst = 1'b1; req = 1'b0; hold = 1'b0; rtype = 2'd0; size = 3'd0; paddr = '0;
    wdata = '0; nc = 1'b0; amo = 1'b0; tid = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ack", 128'(ack), 128'd0);
    check_val("rst_vld", 128'(vld), 128'd0);
    check_val("rst_err", 128'(err), 128'd0);
    check_val("rst_data", data_o, 128'd0);
    check_val("rst_tid_rt", 128'({tid_o, rt_o}), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Known-zero working set.
    send(2'd1, 3'd3, 56'h40, 64'd0, 1'b0, 2'd0, 1'b1);
    send(2'd1, 3'd3, 56'h48, 64'd0, 1'b0, 2'd1, 1'b1);
    send(2'd1, 3'd3, 56'h80, 64'd0, 1'b0, 2'd2, 1'b1);
    send(2'd1, 3'd3, 56'h88, 64'd0, 1'b0, 2'd3, 1'b1);

    // Doubleword store then back-to-back load (read-after-write).
    send(2'd1, 3'd3, 56'h40, 64'h1122334455667788, 1'b0, 2'd1, 1'b1);
    send(2'd0, 3'd3, 56'h40, 64'd0, 1'b0, 2'd2, 1'b1);
    wait_idle();
    check_val("err_clean", 128'(err), 128'(exp_err));

    // Byte store into zero, then misaligned halfword.
    send(2'd1, 3'd3, 56'h40, 64'd0, 1'b0, 2'd3, 1'b1);
    send(2'd1, 3'd0, 56'h43, 64'h00000000AB000000, 1'b0, 2'd0, 1'b1);
    send(2'd0, 3'd3, 56'h40, 64'd0, 1'b0, 2'd1, 1'b1);
    wait_idle();
    check_val("byte_store_word", model[8], 128'h00000000AB000000);
    check_val("err_before_bad", 128'(err), 128'd0);
    send(2'd1, 3'd1, 56'h41, 64'hFFFFFFFFFFFFFFFF, 1'b0, 2'd2, 1'b1);
    send(2'd0, 3'd3, 56'h40, 64'd0, 1'b0, 2'd3, 1'b1);
    wait_idle();
    check_val("err_misaligned", 128'(err), 128'd1);

    // Atomics: ADD, SWAP and an illegal-size AMO.
    send(2'd1, 3'd3, 56'h80, 64'd10, 1'b0, 2'd0, 1'b1);
    send(2'd2, 3'd3, 56'h80, 64'd5, 1'b1, 2'd1, 1'b1);
    send(2'd0, 3'd3, 56'h80, 64'd0, 1'b0, 2'd2, 1'b1);
    send(2'd2, 3'd3, 56'h80, 64'hFF, 1'b0, 2'd3, 1'b1);
    send(2'd0, 3'd3, 56'h80, 64'd0, 1'b0, 2'd0, 1'b1);
    send(2'd2, 3'd2, 56'h88, 64'h77, 1'b1, 2'd1, 1'b1);
    send(2'd0, 3'd3, 56'h88, 64'd0, 1'b0, 2'd2, 1'b1);
    wait_idle();
    check_val("amo_final", model[16], 128'hFF);

    // Back-pressure: exactly D acks while held, then in-order consecutive drain.
    hold = 1'b1;
    for (int t = 0; t < 4; t++) send(2'd0, 3'd3, 56'h40 + 56'(t * 8), 64'd0, 1'b0, 2'(t), 1'b0);
    acks = 0; vlds = 0;
    fork
      send(2'd0, 3'd3, 56'h88, 64'd0, 1'b0, 2'd0, 1'b0);
      begin
        repeat (8) begin @(negedge clk); acks += int'(ack); end
        check_val("hold_noack", 128'(acks), 128'd0);
        hold = 1'b0;
        repeat (4) begin @(negedge clk); vlds += int'(vld); end
        check_val("drain_consec", 128'(vlds), 128'd4);
      end
    join
    wait_idle();

    // Address wrap modulo MemWords*8.
    send(2'd0, 3'd3, 56'h40, 64'd0, 1'b0, 2'd1, 1'b1);
    send(2'd0, 3'd3, 56'h40 + 56'(MW * 8), 64'd0, 1'b0, 2'd2, 1'b1);
    wait_idle();

    // Reset with queued returns.
    hold = 1'b1;
    for (int t = 0; t < 3; t++) send(2'd0, 3'd3, 56'h40, 64'd0, 1'b0, 2'(t), 1'b0);
    rst = 1'b1; req = 1'b1; rtype = 2'd0;
    sb.delete();
    @(negedge clk);
    check_val("ack_in_rst", 128'(ack), 128'd0);
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    check_val("ack_in_rst2", 128'(ack), 128'd0);
    check_val("err_after_rst", 128'(err), 128'd0);
    req = 1'b0;
    exp_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    vlds = 0;
    repeat (10) begin @(negedge clk); vlds += int'(vld); end
    check_val("no_vld_after_rst", 128'(vlds), 128'd0);
    @(posedge clk); #1;
    send(2'd1, 3'd3, 56'h48, 64'hDEADBEEFCAFEF00D, 1'b0, 2'd3, 1'b1);
    send(2'd0, 3'd3, 56'h40, 64'd0, 1'b0, 2'd0, 1'b1);
    wait_idle();
    check_val("err_fresh", 128'(err), 128'd0);

    // Reserved rtype: acked, flags error, no return.
    send(2'd3, 3'd3, 56'h40, 64'd0, 1'b0, 2'd1, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check_val("err_reserved", 128'(err), 128'(exp_err));
    check_val("reserved_noret", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
